// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states,
// stall counter width and default payload/control widths.
package pipe_pkg;

  // Occupancy of the stage; TWO is only reachable in the skid build.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  localparam int STALL_CNT_W = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int CTRL_W_DEF  = 16;

endpackage

// File: rtl/pipe_stage_entry.sv
// One stage entry: valid flag plus control and payload registers.
// clear kills the entry (payload zeroed only when CLR_DATA=1), load captures
// a new entry, drop retires the entry while leaving ctrl/data untouched.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              drop,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Entry register: reset > clear > load > drop > hold.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid build whose in_ready does
// not depend on out_ready; otherwise the stage holds a single entry.
//
// state | meaning
// EMPTY | no entry held
// ONE   | head entry held and presented downstream
// TWO   | head plus skid entry held (skid build only), input blocked
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  occ_state_t        state, state_nx;
  logic              head_valid;
  logic              head_load, head_drop;
  logic [CTRL_W-1:0] head_d_ctrl;
  logic [DATA_W-1:0] head_d_data;
  logic              in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load, skid_drop, head_from_skid;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready    = ~stall & (state != TWO);
  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_d_data = head_from_skid ? skid_data : in_data;
`else
  assign in_ready    = ~stall & (~head_valid | out_ready);
  assign head_d_ctrl = in_ctrl;
  assign head_d_data = in_data;
`endif

  assign out_valid = head_valid & ~stall;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= EMPTY;
    else         state <= state_nx;
  end

  // Next occupancy and entry load/drop controls; flush overrides everything.
  always_comb begin
    state_nx  = state;
    head_load = 1'b0;
    head_drop = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    head_from_skid = 1'b0;
`endif
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            head_load = 1'b1;
            state_nx  = ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_load = 1'b1;
            state_nx  = TWO;
`else
            head_load = 1'b1;
`endif
          end else if (in_xfer) begin
            head_load = 1'b1;
          end else if (out_xfer) begin
            head_drop = 1'b1;
            state_nx  = EMPTY;
          end
        end
        TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_xfer) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_nx       = ONE;
          end
`else
          state_nx = EMPTY;
`endif
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  pipe_stage_entry #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CLR_DATA(CLR_DATA)
  ) u_head (
    .clock (clock),
    .resetn(resetn),
    .load  (head_load),
    .drop  (head_drop),
    .clear (flush),
    .d_ctrl(head_d_ctrl),
    .d_data(head_d_data),
    .valid (head_valid),
    .ctrl  (out_ctrl),
    .data  (out_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_stage_entry #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CLR_DATA(CLR_DATA)
  ) u_skid (
    .clock (clock),
    .resetn(resetn),
    .load  (skid_load),
    .drop  (skid_drop),
    .clear (flush),
    .d_ctrl(in_ctrl),
    .d_data(in_data),
    .valid (skid_valid),
    .ctrl  (skid_ctrl),
    .data  (skid_data)
  );
`endif

  // Saturating count of cycles spent stalled while holding an entry.
  always_ff @(posedge clock) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (stall && !flush && head_valid && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; works for both the default and the
// PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W   = 32;
  localparam int CTRL_W   = 16;
  localparam bit CLR_DATA = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic                   clock = 1'b0;
  logic                   resetn, stall, flush, in_valid, out_ready;
  logic                   in_ready, out_valid;
  logic [CTRL_W-1:0]      in_ctrl, out_ctrl;
  logic [DATA_W-1:0]      in_data, out_data;
  logic [STALL_CNT_W-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR_DATA)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    int                cyc;
  } ent_t;

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   stream_chk = 1'b0;
  int   n_pop  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: push on accepted input, pop/compare on output transfer.
  always @(negedge clock) begin
    ent_t e;
    if (!resetn) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_pop++;
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          if (stream_chk) chk("latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bit ok;
    int n;
    in_valid = 1'b1; in_ctrl = c; in_data = d; ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clock);
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int viol;
    int sc0;
    int p0;
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 16'h5555; in_data = 32'h55;

    // Reset with in_valid high.
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    step();
    chk("rst_out_valid2", 64'(out_valid), 64'd0);

    // Streaming 1..8 back to back.
    stream_chk = 1'b1;
    p0 = n_pop;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 16'(i * 3);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    stream_chk = 1'b0;
    chk("stream_count", 64'(n_pop - p0), 64'd8);
    chk("stream_drain", 64'(sb.size()), 64'd0);

    // Backpressure: DEPTH entries fit, then in_ready falls.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hA + 32'(k); in_ctrl = 16'h100 + 16'(k);
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), (k < DEPTH) ? 64'd1 : 64'd0);
      step();
      if (k >= DEPTH) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = DEPTH; k < 3; k++) send(16'h100 + 16'(k), 32'hA + 32'(k));
    repeat (4) step();
    chk("bp_drain", 64'(sb.size()), 64'd0);

    // Flush of a held entry with incoming input.
    out_ready = 1'b0;
    send(16'hFFFF, 32'h1234);
    chk("fl_held", 64'(out_valid), 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h9999; in_ctrl = 16'h7777;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("fl_out_data",  64'(out_data),  CLR_DATA ? 64'd0 : 64'h1234);

    // Flush together with stall: no count, input discarded.
    send(16'h0042, 32'h4242);
    sc0 = int'(stall_cnt);
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    step();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("fs_out_valid", 64'(out_valid), 64'd0);
    chk("fs_stall_cnt", 64'(stall_cnt), 64'(sc0));

    // Flush with simultaneous input and output transfers.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h600D; in_ctrl = 16'h0001;
    step();
    in_data = 32'hBAD0; flush = 1'b1;
    @(negedge clock);
    chk("fio_in_ready", 64'(in_ready), 64'd1);
    chk("fio_out_valid", 64'(out_valid), 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fio_empty", 64'(out_valid), 64'd0);
    step();
    chk("fio_empty2", 64'(out_valid), 64'd0);

    // Long stall with one entry held: counter saturates, entry preserved.
    out_ready = 1'b0;
    send(16'h0F0F, 32'h77);
    sc0 = int'(stall_cnt);
    stall = 1'b1; in_valid = 1'b1; in_data = 32'hEEEE; out_ready = 1'b1;
    viol = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) viol++;
      if (i == 100) chk("stall_cnt_100", 64'(stall_cnt), 64'(sc0 + 100));
      step();
    end
    chk("stall_blocked", 64'(viol), 64'd0);
    chk("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
    chk("stall_out_data", 64'(out_data), 64'h77);
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    chk("stall_drain", 64'(sb.size()), 64'd0);
    chk("stall_cnt_hold", 64'(stall_cnt), 64'hFFFF);

    // Random mix of stall / out_ready / in_valid for ordering.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      step();
    end
    in_valid = 1'b0; stall = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("rand_drain", 64'(sb.size()), 64'd0);

    // Reset mid-transfer discards held entries and clears stall_cnt.
    out_ready = 1'b0;
    send(16'h0033, 32'h3333);
    resetn = 1'b0; in_valid = 1'b1;
    step();
    resetn = 1'b1; in_valid = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready",  64'(in_ready),  64'd1);
    chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mrst_out_ctrl",  64'(out_ctrl),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload data width in bits (1..64).
REQ-002 Parameter CTRL_W, default 16, control-field width in bits (1..32), carrying fields such as RegWrite, MemWrite, MemOp and Rd.
REQ-003 Parameter CLR_DATA, default 1: when 1, flush also zeroes data; when 0, flush zeroes only valid and control.
REQ-004 Port clock, input, 1, single rising-edge clock for all state.
REQ-005 Port resetn, input, 1, reset: synchronous, active-low, sampled on the rising edge of clock.
REQ-006 Port stall, input, 1, freezes the stage.
REQ-007 Port flush, input, 1, kills the stage contents.
REQ-008 Port in_valid, input, 1, upstream entry present.
REQ-009 Port in_ready, output, 1, stage accepts an entry this cycle.
REQ-010 Port in_ctrl, input, CTRL_W, upstream control bits.
REQ-011 Port in_data, input, DATA_W, upstream payload.
REQ-012 Port out_valid, output, 1, head entry presented downstream.
REQ-013 Port out_ready, input, 1, downstream accepts the head entry.
REQ-014 Port out_ctrl, output, CTRL_W, head control bits.
REQ-015 Port out_data, output, DATA_W, head payload.
REQ-016 Port stall_cnt, output, 16, saturating count of occupied-and-stalled cycles.

Function
REQ-017 The stage SHALL perform an input transfer when in_valid & in_ready and an output transfer when out_valid & out_ready.
REQ-018 Per-cycle priority SHALL be resetn low > flush > stall > normal handshake.
REQ-019 With flush=1, at the next edge all entries SHALL become invalid and all stored ctrl SHALL become 0; stored data SHALL become 0 when CLR_DATA=1. The incoming entry in that cycle SHALL be discarded.
REQ-020 With stall=1 and flush=0, in_ready and out_valid SHALL be 0 combinationally, and all stored state except stall_cnt SHALL hold.
REQ-021 Without stall, latency SHALL be exactly one cycle: an entry accepted at edge N is presented on out_* after edge N.
REQ-022 out_ctrl and out_data SHALL be driven directly from registers, with no combinational path from in_* to out_*.
REQ-023 The order of entries SHALL be preserved, with none lost or duplicated under any mix of stall, out_ready and in_valid.
REQ-024 stall_cnt SHALL increment by 1 on each edge where stall=1, flush=0 and at least one entry is held; it SHALL saturate at 0xFFFF and SHALL NOT be cleared by flush.
REQ-025 Occupancy states SHALL be EMPTY, ONE and, with the skid feature only, TWO.
REQ-026 EMPTY transitions to ONE on an input transfer.
REQ-027 ONE transitions to EMPTY on an output transfer with no input transfer.
REQ-028 ONE transitions to TWO (skid only) on an input transfer with no output transfer.
REQ-029 TWO transitions to ONE on an output transfer; the skid entry then becomes the head.
REQ-030 A simultaneous input and output transfer in ONE SHALL stay in ONE with the new entry at the head.
REQ-031 Any state SHALL transition to EMPTY on flush.

Reset
REQ-032 While resetn=0 at an edge, the state SHALL become EMPTY and stall_cnt, out_ctrl and out_data SHALL become 0; out_valid SHALL therefore be 0 from the first edge after reset.
REQ-033 Reset asserted mid-transfer SHALL discard all held entries; in_ready SHALL be 1 in the first cycle after resetn returns high, provided stall=0.

Configuration
REQ-034 Macro PIPE_STAGE_SKID_EN defined: the stage SHALL hold two entries, and in_ready SHALL equal ~stall & (state != TWO), with no combinational dependence on out_ready.
REQ-035 Macro PIPE_STAGE_SKID_EN undefined: the stage SHALL hold one entry, and in_ready SHALL equal ~stall & (~head_valid | out_ready); state TWO SHALL not exist.

Structure
REQ-036 Package pipe_pkg SHALL hold the occupancy state enum (EMPTY, ONE, TWO), the STALL_CNT_W=16 constant, and the default DATA_W and CTRL_W values.
REQ-037 A single sub-module, pipe_stage_entry, SHALL implement one valid+ctrl+data register with load, hold and clear; it is instantiated once for the head and once more for the skid entry when PIPE_STAGE_SKID_EN is defined.

Verification
REQ-038 Reset: drive resetn=0 for 2 cycles with in_valid=1, then release -> out_valid=0, stall_cnt=0, in_ready=1.
REQ-039 Streaming: send in_data 1..8 with out_ready=1 and stall=0 -> out_data 1..8 in order, each one cycle after acceptance, with no gaps.
REQ-040 Backpressure (skid build): hold out_ready=0 while sending 0xA, 0xB, 0xC -> in_ready falls after 2 accepts; on out_ready=1 the outputs are 0xA then 0xB, and 0xC is accepted afterwards.
REQ-041 Flush: with ctrl=0xFFFF and data=0x1234 held, assert flush with in_valid=1 for one cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0 (CLR_DATA=1) or 0x1234 (CLR_DATA=0).
REQ-042 Stall: with one entry held, assert stall for 70000 cycles -> out_valid=0 and in_ready=0 throughout, stall_cnt=0xFFFF, and the entry is unchanged after release.
REQ-043 Flush+stall together, and flush with simultaneous input and output transfers -> flush wins: state EMPTY, the input is discarded, and stall_cnt does not increment.
